// File: rtl/sap2_pkg.sv
// sap2_pkg
// Shared definitions for the SAP-2 mini CPU and its program loader:
// default port widths, the loader state encoding and a width helper
// used to size the cycle counter.
package sap2_pkg;

    // Default widths of the CPU programming port (address / data word).
    localparam int SAP2_AW = 8;
    localparam int SAP2_DW = 12;

    // Loader sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRECLR  = 3'd1,
        ST_LOAD    = 3'd2,
        ST_POSTCLR = 3'd3,
        ST_RUN     = 3'd4
    } loader_state_t;

    // Smallest width (at least 1) able to hold the value max_val.
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sap2_cycle_cnt.sv
// sap2_cycle_cnt
// Loadable down-counter with a zero flag. Times both the per-word hold
// of the programming port and the CPU clear pulses.
// Ports:
//   clk      - clock, rising edge
//   clr      - asynchronous active-high reset (count returns to 0)
//   load     - load load_val this cycle (has priority over dec)
//   load_val - value to load
//   dec      - decrement this cycle; the count stops at 0
//   cnt      - current count
//   zero     - count is 0
module sap2_cycle_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (dec && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - W'(1);
        end
    end

    assign cnt  = cnt_reg;
    assign zero = (cnt_reg == '0);

endmodule

// File: rtl/sap2_loader.sv
// sap2_loader
// Program loader and run sequencer for the SAP-2 mini CPU programming
// port. Host words arrive over valid/ready and are written to consecutive
// CPU addresses from 0; the CPU is cleared before and after programming
// and then released to run.
// Ports:
//   clk, clr            - clock / asynchronous active-high reset
//   start               - one-cycle request to begin a load (IDLE or RUN)
//   in_valid/in_data/in_last/in_ready - host word stream
//   prog_o, a_o, d_o, cpu_clr_o       - CPU programming port
//   busy                - PRECLR, LOAD or POSTCLR
//   running             - CPU released to execute
//   ovf                 - sticky: program ran past the last address
//   words_loaded        - words accepted in the current / last load
// All outputs come straight from registers.
module sap2_loader
    import sap2_pkg::*;
#(
    parameter int AW          = SAP2_AW,
    parameter int DW          = SAP2_DW,
    parameter int WORD_CYCLES = 2,
    parameter int CLR_CYCLES  = 2
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          start,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          in_ready,
    output logic          prog_o,
    output logic [AW-1:0] a_o,
    output logic [DW-1:0] d_o,
    output logic          cpu_clr_o,
    output logic          busy,
    output logic          running,
    output logic          ovf,
    output logic [AW:0]   words_loaded
);

    localparam int CNT_MAX = ((WORD_CYCLES > CLR_CYCLES) ? WORD_CYCLES : CLR_CYCLES) - 1;
    localparam int CW      = cnt_width(CNT_MAX);
    localparam logic [AW:0] WORDS_MAX = {1'b1, {AW{1'b0}}};

    loader_state_t state_reg, state_next;
    logic [AW-1:0] a_reg, a_next;
    logic [DW-1:0] d_reg, d_next;
    logic [AW:0]   words_reg, words_next;
    logic          ovf_reg, ovf_next;
    logic          done_reg, done_next;   // last word taken, leave LOAD after its hold
    logic          in_ready_reg, prog_reg, cpu_clr_reg, busy_reg, running_reg;

    logic          cnt_load, cnt_dec, cnt_zero, cnt_zero_next;
    logic [CW-1:0] cnt_val, cnt;
    logic          accept, at_top_addr;

    sap2_cycle_cnt #(.W(CW)) u_cnt (
        .clk      (clk),
        .clr      (clr),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    assign accept      = (state_reg == ST_LOAD) && in_valid && in_ready_reg;
    assign at_top_addr = (words_reg[AW-1:0] == {AW{1'b1}});

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        d_next     = d_reg;
        words_next = words_reg;
        ovf_next   = ovf_reg;
        done_next  = done_reg;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        cnt_dec    = 1'b0;
        case (state_reg)
            ST_IDLE, ST_RUN: begin
                if (start) begin
                    state_next = ST_PRECLR;
                    a_next     = '0;
                    d_next     = '0;
                    words_next = '0;
                    ovf_next   = 1'b0;
                    done_next  = 1'b0;
                    cnt_load   = 1'b1;
                    cnt_val    = CW'(CLR_CYCLES - 1);
                end
            end
            ST_PRECLR: begin
                if (cnt_zero) begin
                    state_next = ST_LOAD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    a_next   = words_reg[AW-1:0];
                    d_next   = in_data;
                    cnt_load = 1'b1;
                    cnt_val  = CW'(WORD_CYCLES - 1);
                    if (words_reg != WORDS_MAX) begin
                        words_next = words_reg + {{AW{1'b0}}, 1'b1};
                    end
                    if (in_last || at_top_addr) begin
                        done_next = 1'b1;
                    end
                    if (at_top_addr && !in_last) begin
                        ovf_next = 1'b1;
                    end
                end else if (done_reg && cnt_zero) begin
                    state_next = ST_POSTCLR;
                    cnt_load   = 1'b1;
                    cnt_val    = CW'(CLR_CYCLES - 1);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_POSTCLR: begin
                if (cnt_zero) begin
                    state_next = ST_RUN;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Counter value one edge ahead, so in_ready can itself be a register
    // and no path runs from in_valid to in_ready.
    always_comb begin
        if (cnt_load) begin
            cnt_zero_next = (cnt_val == '0);
        end else if (cnt_dec) begin
            cnt_zero_next = (cnt <= CW'(1));
        end else begin
            cnt_zero_next = cnt_zero;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg    <= ST_IDLE;
            a_reg        <= '0;
            d_reg        <= '0;
            words_reg    <= '0;
            ovf_reg      <= 1'b0;
            done_reg     <= 1'b0;
            in_ready_reg <= 1'b0;
            prog_reg     <= 1'b0;
            cpu_clr_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            running_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            a_reg        <= a_next;
            d_reg        <= d_next;
            words_reg    <= words_next;
            ovf_reg      <= ovf_next;
            done_reg     <= done_next;
            in_ready_reg <= (state_next == ST_LOAD) && cnt_zero_next && !done_next;
            prog_reg     <= (state_next == ST_LOAD);
            cpu_clr_reg  <= (state_next == ST_PRECLR) || (state_next == ST_POSTCLR);
            busy_reg     <= (state_next == ST_PRECLR) || (state_next == ST_LOAD) ||
                            (state_next == ST_POSTCLR);
            running_reg  <= (state_next == ST_RUN);
        end
    end

    assign in_ready     = in_ready_reg;
    assign prog_o       = prog_reg;
    assign a_o          = a_reg;
    assign d_o          = d_reg;
    assign cpu_clr_o    = cpu_clr_reg;
    assign busy         = busy_reg;
    assign running      = running_reg;
    assign ovf          = ovf_reg;
    assign words_loaded = words_reg;

endmodule

// File: tb/tb_sap2_loader.sv
// tb_sap2_loader
// Two loaders share one clock: u_dut with 2-cycle word hold / clear pulse
// and u_dut_fast with 1-cycle hold / pulse. sel routes the host stimulus
// to one of them and picks which one's outputs are observed. Each load
// session is judged against a CPU memory image built from prog_o/a_o/d_o
// plus pulse lengths, hold times and accept spacing predicted from the
// loader's rules.
module tb_sap2_loader;

    logic        clk = 1'b0;
    logic        clr;
    logic        sel;
    logic        start, in_valid, in_last;
    logic [11:0] in_data;

    // observed (muxed) outputs
    logic        in_ready, prog_o, cpu_clr_o, busy, running, ovf;
    logic [7:0]  a_o;
    logic [11:0] d_o;
    logic [8:0]  words_loaded;

    logic        s0_start, s0_valid, s1_start, s1_valid;
    logic        r0, p0, c0, b0, n0, o0, r1, p1, c1, b1, n1, o1;
    logic [7:0]  a0, a1;
    logic [11:0] dd0, dd1;
    logic [8:0]  w0, w1;

    int n_tests = 0;
    int n_fail  = 0;
    logic [11:0] prog_words [0:299];

    always #5 clk = ~clk;

    assign s0_start = start & ~sel;
    assign s0_valid = in_valid & ~sel;
    assign s1_start = start & sel;
    assign s1_valid = in_valid & sel;

    sap2_loader #(.AW(8), .DW(12), .WORD_CYCLES(2), .CLR_CYCLES(2)) u_dut (
        .clk(clk), .clr(clr), .start(s0_start), .in_valid(s0_valid),
        .in_data(in_data), .in_last(in_last), .in_ready(r0), .prog_o(p0),
        .a_o(a0), .d_o(dd0), .cpu_clr_o(c0), .busy(b0), .running(n0),
        .ovf(o0), .words_loaded(w0)
    );

    sap2_loader #(.AW(8), .DW(12), .WORD_CYCLES(1), .CLR_CYCLES(1)) u_dut_fast (
        .clk(clk), .clr(clr), .start(s1_start), .in_valid(s1_valid),
        .in_data(in_data), .in_last(in_last), .in_ready(r1), .prog_o(p1),
        .a_o(a1), .d_o(dd1), .cpu_clr_o(c1), .busy(b1), .running(n1),
        .ovf(o1), .words_loaded(w1)
    );

    assign in_ready     = sel ? r1  : r0;
    assign prog_o       = sel ? p1  : p0;
    assign cpu_clr_o    = sel ? c1  : c0;
    assign busy         = sel ? b1  : b0;
    assign running      = sel ? n1  : n0;
    assign ovf          = sel ? o1  : o0;
    assign a_o          = sel ? a1  : a0;
    assign d_o          = sel ? dd1 : dd0;
    assign words_loaded = sel ? w1  : w0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One complete load: start pulse, host words, end in RUN.
    //   n          words the host offers
    //   last_idx   index carrying in_last (-1: none)
    //   stall_after host drops in_valid for stall_len cycles after this many accepts
    //   start_at   pulse start during LOAD once this many words are accepted
    task automatic run_session(input string nm, input int n, input int last_idx,
                               input int stall_after, input int stall_len, input int start_at);
        int wc, exp_n, acc, cyc, pre_clr, post_clr, last_acc_cyc, stall_left, last_a;
        int gap_bad, skip_bad, hold_bad, mem_bad, ctl_bad, stall_bad;
        bit exp_ovf, seen_prog, first_ready, stalled, sdone;
        int hcnt [0:255];
        logic [11:0] mem [0:255];
        wc = sel ? 1 : 2;
        exp_n   = (last_idx >= 0 && last_idx < 256) ? last_idx + 1 : 256;
        exp_ovf = !(last_idx >= 0 && last_idx < 256);
        acc = 0; cyc = 0; pre_clr = 0; post_clr = 0; last_acc_cyc = 0;
        stall_left = 0; last_a = -1;
        gap_bad = 0; skip_bad = 0; hold_bad = 0; mem_bad = 0; ctl_bad = 0; stall_bad = 0;
        seen_prog = 0; first_ready = 0; stalled = 0; sdone = 0;
        for (int i = 0; i < 256; i++) begin
            hcnt[i] = 0;
            mem[i]  = '0;
        end
        in_valid = 0; in_last = 0;
        start = 1;
        @(negedge clk);
        start = 0;
        chk({nm, "_start_words"}, 32'(words_loaded), 0);
        chk({nm, "_start_ovf"}, 32'(ovf), 0);
        chk({nm, "_start_a"}, 32'(a_o), 0);
        chk({nm, "_start_d"}, 32'(d_o), 0);
        while (!running && cyc < 2000) begin
            start = 0;
            // observe this cycle
            if (!busy) ctl_bad++;
            if (cpu_clr_o) begin
                if (prog_o) ctl_bad++;
                if (seen_prog) post_clr++;
                else pre_clr++;
            end
            if (prog_o) begin
                if (!seen_prog) first_ready = in_ready;
                seen_prog = 1;
                mem[a_o] = d_o;
                if (acc > 0) hcnt[a_o]++;
                if (int'(a_o) != last_a) begin
                    if (int'(a_o) != last_a + 1) skip_bad++;
                    last_a = int'(a_o);
                end
            end
            // drive the host for the coming edge
            if (stall_left > 0) begin
                in_valid = 0;
                stall_left--;
                if (int'(a_o) != stall_after - 1 || d_o != prog_words[stall_after - 1]) stall_bad++;
            end else if (acc < n) begin
                in_valid = 1;
                in_data  = prog_words[acc];
                in_last  = (acc == last_idx);
            end else begin
                in_valid = 0;
                in_last  = 0;
            end
            if (acc == start_at && !sdone && seen_prog) begin
                start = 1;
                sdone = 1;
            end
            if (in_valid && in_ready) begin
                if (acc > 0 && !stalled && (cyc - last_acc_cyc) != wc) gap_bad++;
                stalled = 0;
                last_acc_cyc = cyc;
                acc++;
                if (acc == stall_after) begin
                    stall_left = stall_len;
                    stalled = 1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 0; in_last = 0; start = 0;
        for (int i = 0; i < exp_n; i++) begin
            if (mem[i] != prog_words[i]) mem_bad++;
            if (i != stall_after - 1 && hcnt[i] != wc) hold_bad++;
        end
        chk({nm, "_reached_run"}, 32'(running), 1);
        chk({nm, "_preclr_len"}, 32'(pre_clr), 32'(wc));
        chk({nm, "_postclr_len"}, 32'(post_clr), 32'(wc));
        chk({nm, "_first_ready"}, 32'(first_ready), 1);
        chk({nm, "_accepted"}, 32'(acc), 32'(exp_n));
        chk({nm, "_words_loaded"}, 32'(words_loaded), 32'(exp_n));
        chk({nm, "_ovf"}, 32'(ovf), 32'(exp_ovf));
        chk({nm, "_a_final"}, 32'(a_o), 32'((exp_n - 1) % 256));
        chk({nm, "_d_final"}, 32'(d_o), 32'(prog_words[exp_n - 1]));
        chk({nm, "_run_ctl"}, {28'd0, prog_o, cpu_clr_o, busy, in_ready}, 0);
        chk({nm, "_mem_image"}, 32'(mem_bad), 0);
        chk({nm, "_addr_skip"}, 32'(skip_bad), 0);
        chk({nm, "_hold_time"}, 32'(hold_bad), 0);
        chk({nm, "_accept_gap"}, 32'(gap_bad), 0);
        chk({nm, "_ctl_seq"}, 32'(ctl_bad), 0);
        chk({nm, "_stall_hold"}, 32'(stall_bad), 0);
        // host keeps offering a word while running: nothing is taken
        in_valid = 1;
        repeat (3) @(negedge clk);
        chk({nm, "_run_stays"}, {30'd0, running, in_ready}, 32'b10);
        in_valid = 0;
        $display("[TB] session %s: %0d words offered, %0d accepted, ovf=%0d, %0d cycles",
                 nm, n, acc, ovf, cyc);
    endtask

    initial begin
        int k;
        clr = 1; sel = 0; start = 0; in_valid = 0; in_last = 0; in_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_ctl", {27'd0, prog_o, cpu_clr_o, in_ready, busy, running}, 0);
        chk("reset_ovf", 32'(ovf), 0);
        chk("reset_a", 32'(a_o), 0);
        chk("reset_d", 32'(d_o), 0);
        chk("reset_words", 32'(words_loaded), 0);
        clr = 0;
        @(negedge clk);

        // fixed 7-word program
        prog_words[0] = 12'hFD0; prog_words[1] = 12'h307; prog_words[2] = 12'hF50;
        prog_words[3] = 12'hFE0; prog_words[4] = 12'h007; prog_words[5] = 12'hFE0;
        prog_words[6] = 12'hFF0;
        run_session("fixed7", 7, 6, -1, 0, -1);

        // random words, host stall after word 2, start pulsed mid-LOAD
        for (int i = 0; i < 300; i++) prog_words[i] = 12'($urandom);
        prog_words[1] = 12'h108;
        run_session("stall", 10, 9, 2, 5, 4);

        // restart from RUN, overflow past 256 addresses
        for (int i = 0; i < 300; i++) prog_words[i] = 12'($urandom);
        run_session("overflow", 300, -1, -1, 0, -1);

        // restart from RUN after overflow: ovf must clear
        for (int i = 0; i < 300; i++) prog_words[i] = 12'($urandom);
        run_session("after_ovf", 5, 4, -1, 0, -1);

        // exactly 256 words with in_last on the top address: no overflow
        for (int i = 0; i < 300; i++) prog_words[i] = 12'($urandom);
        run_session("full256", 256, 255, -1, 0, -1);

        // reset mid-LOAD after 3 words
        start = 1;
        @(negedge clk);
        start = 0;
        k = 0;
        in_valid = 1; in_last = 0;
        for (int c = 0; c < 50 && k < 3; c++) begin
            in_data = 12'($urandom);
            if (in_ready) k++;
            @(negedge clk);
        end
        in_valid = 0;
        chk("rstmid_accepts", 32'(k), 3);
        chk("rstmid_a_before", 32'(a_o), 2);
        chk("rstmid_prog_before", 32'(prog_o), 1);
        #1 clr = 1;
        #1;
        chk("rstmid_async_ctl", {27'd0, prog_o, cpu_clr_o, in_ready, busy, running}, 0);
        chk("rstmid_async_a", 32'(a_o), 0);
        chk("rstmid_async_words", 32'(words_loaded), 0);
        @(negedge clk);
        clr = 0;
        @(negedge clk);
        chk("rstmid_idle_ctl", {27'd0, prog_o, cpu_clr_o, in_ready, busy, running}, 0);
        chk("rstmid_idle_words", 32'(words_loaded), 0);

        // single-cycle hold and clear pulses
        sel = 1;
        @(negedge clk);
        for (int i = 0; i < 300; i++) prog_words[i] = 12'($urandom);
        run_session("fast6", 6, 5, -1, 0, -1);
        for (int i = 0; i < 300; i++) prog_words[i] = 12'($urandom);
        run_session("fast_stall", 20, 19, 7, 3, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
